// File: rtl/ysyx_22040750_mdu.sv
// ysyx_22040750_mdu: iterative RV64M multiply/divide unit (shift-add multiply, restoring divide, 1 bit/cycle)
// Ports: I_sys_clk/I_rst clock and sync active-high reset; I_start pulse samples I_op (one-hot
// MUL/MULH/DIV/REM), I_sext (src1/src2 signed), I_word (*W op), I_src1, I_src2; I_allowout accepts
// the result; I_flush aborts (only with YSYX_22040750_MDU_FLUSH_EN); O_busy, O_valid, O_result.
module ysyx_22040750_mdu (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_start,
    input  logic [3:0]  I_op,
    input  logic [1:0]  I_sext,
    input  logic        I_word,
    input  logic [63:0] I_src1,
    input  logic [63:0] I_src2,
    input  logic        I_allowout,
`ifdef YSYX_22040750_MDU_FLUSH_EN
    input  logic        I_flush,
`endif
    output logic        O_busy,
    output logic        O_valid,
    output logic [63:0] O_result
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e         state_q, state_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [127:0]   acc_q, acc_d, mc_q, mc_d;
    logic [63:0]    mp_q, mp_d, res_q, res_d;
    logic [2:0]     op_q, op_d;
    logic           word_q, word_d, neg_q, neg_d, rneg_q, rneg_d;
    logic           flush;
`ifdef YSYX_22040750_MDU_FLUSH_EN
    assign flush = I_flush;
`else
    assign flush = 1'b0;
`endif
    logic [63:0]  ext1, ext2, mag1, mag2, sh_lo, rn, qf, rf, raw, fix;
    logic [127:0] mul_acc, div_acc, p;
    logic         neg1, neg2, div_op, b_zero, ge, is_mul;
    assign ext1    = I_word ? {{32{I_sext[1] & I_src1[31]}}, I_src1[31:0]} : I_src1;
    assign ext2    = I_word ? {{32{I_sext[0] & I_src2[31]}}, I_src2[31:0]} : I_src2;
    assign neg1    = I_sext[1] & ext1[63];
    assign neg2    = I_sext[0] & ext2[63];
    assign mag1    = neg1 ? -ext1 : ext1;
    assign mag2    = neg2 ? -ext2 : ext2;
    assign div_op  = I_op[2] | I_op[3];
    assign b_zero  = ext2 == 64'd0;
    assign is_mul  = |op_q[1:0];
    assign mul_acc = acc_q + (mp_q[0] ? mc_q : 128'd0);
    // Restoring step: remainder in acc[127:64], dividend/quotient shifts out of/into acc[63:0].
    // The shifted partial remainder is 65 bits; bit 64 is acc_q[127].
    assign sh_lo   = {acc_q[126:64], acc_q[63]};
    assign ge      = {acc_q[127], sh_lo} >= {1'b0, mc_q[63:0]};
    assign rn      = ge ? sh_lo - mc_q[63:0] : sh_lo;
    assign div_acc = {rn, acc_q[62:0], ge};
    assign p       = neg_q ? -mul_acc : mul_acc;
    assign qf      = neg_q ? -div_acc[63:0] : div_acc[63:0];
    assign rf      = rneg_q ? -div_acc[127:64] : div_acc[127:64];
    assign raw     = op_q[0] ? p[63:0] : op_q[1] ? p[127:64] : op_q[2] ? qf : rf;
    assign fix     = word_q ? {{32{raw[31]}}, raw[31:0]} : raw;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        op_d    = op_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        case (state_q)
            IDLE: if (I_start) begin
                op_d   = I_op[2:0];
                word_d = I_word;
                neg_d  = neg1 ^ neg2;
                rneg_d = neg1;
                cnt_d  = I_word ? 7'd32 : 7'd64;
                if (div_op && b_zero) begin
                    state_d = DONE;
                    res_d   = I_op[2] ? '1 : (I_word ? {{32{I_src1[31]}}, I_src1[31:0]} : I_src1);
                end else if (|I_op[1:0]) begin
                    state_d = CALC;
                    acc_d   = '0;
                    mc_d    = {64'd0, mag1};
                    mp_d    = mag2;
                end else begin
                    // Word dividends are left-aligned so 32 steps consume exactly their bits.
                    state_d = CALC;
                    acc_d   = {64'd0, I_word ? {mag1[31:0], 32'd0} : mag1};
                    mc_d    = {64'd0, mag2};
                    mp_d    = '0;
                end
            end
            CALC: begin
                cnt_d = cnt_q - 7'd1;
                acc_d = is_mul ? mul_acc : div_acc;
                mc_d  = is_mul ? mc_q << 1 : mc_q;
                mp_d  = mp_q >> 1;
                if (cnt_q == 7'd1) begin
                    state_d = DONE;
                    res_d   = fix;
                end
            end
            DONE: state_d = I_allowout ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            op_q    <= op_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end
    assign O_busy   = state_q != IDLE;
    assign O_valid  = state_q == DONE;
    assign O_result = res_q;
endmodule

// File: tb/tb_ysyx_22040750_mdu.sv
// tb_ysyx_22040750_mdu: directed and randomized checks of the MDU against an arithmetic reference model
module tb_ysyx_22040750_mdu;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, word = 1'b0, allowout = 1'b0;
    logic [3:0]  op = '0;
    logic [1:0]  sx = '0;
    logic [63:0] src1 = '0, src2 = '0, result;
    logic        busy, valid;
`ifdef YSYX_22040750_MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif
    int total = 0, fails = 0;

    ysyx_22040750_mdu dut (
        .I_sys_clk (clk),
        .I_rst     (rst),
        .I_start   (start),
        .I_op      (op),
        .I_sext    (sx),
        .I_word    (word),
        .I_src1    (src1),
        .I_src2    (src2),
        .I_allowout(allowout),
`ifdef YSYX_22040750_MDU_FLUSH_EN
        .I_flush   (flush),
`endif
        .O_busy    (busy),
        .O_valid   (valid),
        .O_result  (result)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] MUL = 4'b0001, MULH = 4'b0010, DIV = 4'b0100, REM = 4'b1000;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sext32(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    // Reference: full-width arithmetic on the extended operands, RISC-V corner rules applied explicitly.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [1:0] s, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  ea, eb, r;
        logic [127:0] wa, wb, pr;
        ea = w ? (s[1] ? sext32(a) : {32'd0, a[31:0]}) : a;
        eb = w ? (s[0] ? sext32(b) : {32'd0, b[31:0]}) : b;
        wa = s[1] ? {{64{ea[63]}}, ea} : {64'd0, ea};
        wb = s[0] ? {{64{eb[63]}}, eb} : {64'd0, eb};
        pr = wa * wb;
        if (o[0]) r = pr[63:0];
        else if (o[1]) r = pr[127:64];
        else if (eb == 64'd0) r = o[2] ? '1 : (w ? sext32(a) : a);
        else if (s == 2'b11) begin
            if (!w && ea == 64'h8000_0000_0000_0000 && eb == '1) r = o[2] ? ea : 64'd0;
            else r = o[2] ? 64'($signed(ea) / $signed(eb)) : 64'($signed(ea) % $signed(eb));
        end else r = o[2] ? ea / eb : ea % eb;
        return w ? sext32(r) : r;
    endfunction

    task automatic run(input string tag, input logic [3:0] o, input logic [1:0] s, input logic w,
                       input logic [63:0] a, input logic [63:0] b, input int hold,
                       input logic [63:0] exp, input int exp_lat);
        int lat;
        op = o; sx = s; word = w; src1 = a; src2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_v"}, {63'd0, valid}, 64'd1);
            chk({tag, "_hold_r"}, result, exp);
        end
        allowout = 1'b1;
        @(posedge clk); #1;
        allowout = 1'b0;
        chk({tag, "_acc_v"}, {63'd0, valid}, 64'd0);
        chk({tag, "_acc_b"}, {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [63:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    logic [3:0] t_op [13] = '{MUL, MULH, MULH, MULH, DIV, DIV, REM, REM, MUL, DIV, DIV, REM, REM};
    logic [1:0] t_sx [13] = '{2'b00, 2'b11, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b00,
                              2'b11, 2'b11, 2'b00, 2'b11, 2'b00};
    logic       t_w  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_result", result, 64'd0);

        run("mul_neg", MUL, 2'b11, 0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 4, 64'hFFFF_FFFF_FFFF_FFF1, 64);
        run("mulhu", MULH, 2'b00, 0, '1, '1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run("mulhsu", MULH, 2'b10, 0, '1, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("divu_0", DIV, 2'b00, 0, 64'd7, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run("rem_0", REM, 2'b11, 0, 64'd7, 64'd0, 0, 64'd7, 0);
        run("divw_ovf", DIV, 2'b11, 1, 64'h0000_0000_8000_0000, '1, 0, 64'hFFFF_FFFF_8000_0000, 32);
        run("remw_ovf", REM, 2'b11, 1, 64'h0000_0000_8000_0000, '1, 0, 64'd0, 32);
        run("rem_neg", REM, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run("div_neg", DIV, 2'b11, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run("div_ovf", DIV, 2'b11, 0, 64'h8000_0000_0000_0000, '1, 0, 64'h8000_0000_0000_0000, 64);

        op = DIV; sx = 2'b11; word = 1'b0; src1 = 64'd100; src2 = 64'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_valid", {63'd0, valid}, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_result", result, 64'd0);
        run("mul_after_rst", MUL, 2'b11, 0, 64'd6, 64'd7, 0, 64'd42, 64);

`ifdef YSYX_22040750_MDU_FLUSH_EN
        begin
            int seen = 0;
            op = MUL; sx = 2'b00; word = 1'b0; src1 = 64'd5; src2 = 64'd9; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (10) @(posedge clk);
            #1;
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            for (int i = 0; i < 80; i++) begin
                if (valid) seen++;
                @(posedge clk); #1;
            end
            chk("flush_no_valid", 64'(seen), 64'd0);
            chk("flush_busy", {63'd0, busy}, 64'd0);
        end
`endif

        for (int k = 0; k < 40; k++) begin
            int idx;
            logic [63:0] a, b, eb;
            idx = $urandom_range(0, 12);
            a = rnd_opnd();
            b = rnd_opnd();
            eb = t_w[idx] ? {32'd0, b[31:0]} : b;
            run($sformatf("rnd%0d", k), t_op[idx], t_sx[idx], t_w[idx], a, b, 0,
                model(t_op[idx], t_sx[idx], t_w[idx], a, b),
                (t_op[idx][3:2] != 2'b00 && eb == 64'd0) ? 0 : (t_w[idx] ? 32 : 64));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule

// File: doc/ysyx_22040750_mdu.md
# ysyx_22040750_mdu

- Iterative multiply/divide unit for RV64M, located in the EX stage directly downstream of the ID/EX pipeline register.
- Started by the register's one-cycle multicycle-op pulse. Operands come from the EX operand muxes.
- Its result-valid output drives the register's ALU-output-valid input, so the instruction is held in ID/EX until the result is ready and accepted.
- Shift-add multiply and restoring divide; one bit per cycle.

## Interface
Parameters: none.

Ports:
- I_sys_clk  in  1  clock; all state updates on rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_start  in  1  one-cycle start pulse; operands and op sampled on this edge.
- I_op  in  4  one-hot op: [0] MUL (low product), [1] MULH (high product), [2] DIV, [3] REM.
- I_sext  in  2  [1] src1 signed, [0] src2 signed (MULHSU = 2'b10).
- I_word  in  1  RV64 *W variant: 32-bit operation, result sign-extended from bit 31.
- I_src1  in  64  multiplicand / dividend.
- I_src2  in  64  multiplier / divisor.
- I_allowout  in  1  downstream accepts result this cycle.
- I_flush  in  1  abort; present only with YSYX_22040750_MDU_FLUSH_EN.
- O_busy  out  1  state != IDLE.
- O_valid  out  1  O_result valid; high only in DONE.
- O_result  out  64  final result, registered.

## Operation
State machine:
- IDLE: I_start=1 → CALC. Exception: DIV/REM with zero divisor goes directly to DONE.
  - On the CALC transition: latch |a|, |b| and the result sign; set cnt = 64, or 32 if I_word.
- CALC: one iteration per cycle, cnt decrements. When cnt reaches 1, the final iteration runs, sign fix-up is applied and O_result is loaded on the same edge → DONE.
- DONE: O_valid=1. I_allowout=1 → IDLE on that edge. Otherwise hold O_result and O_valid.

Operand preparation:
- Word ops: each operand is taken from bits [31:0] and extended per I_sext. Sign-extended if its signed bit is set, else zero-extended.
- Signed operand: magnitude = two's-complement negation when negative.

Multiply:
- 128-bit accumulator, shift-add.
- MUL returns product[63:0]; MULH returns product[127:64].
- The product is negated if exactly one signed operand is negative.
- Word MUL: result = sext(product[31:0]). MULH with I_word is unused; its result is don't-care.

Divide (restoring):
- Quotient negated if the operand signs differ and the operation is signed.
- Remainder takes the dividend's sign.

Divide-by-zero:
- Quotient = all ones (word: 0xFFFFFFFFFFFFFFFF).
- Remainder = dividend (word: sext(src1[31:0])).

Signed overflow (most negative / −1):
- Quotient = dividend, remainder = 0.
- Falls out of the magnitude algorithm; it must not be special-cased incorrectly.

I_start handling:
- I_start outside IDLE is ignored. It cannot occur, because the ID/EX register blocks new input until O_valid && allowout.

Reset:
- State IDLE, cnt=0, O_valid=0, O_busy=0, O_result=0, all internal accumulators 0.

## Timing
- Start sampled at edge T.
- 64-bit op: O_valid first high in the cycle after edge T+64. Word op: after edge T+32.
- Divide-by-zero: O_valid high in the cycle after edge T (1-cycle latency).
- O_result stable for the entire DONE interval.
- Acceptance: O_valid && I_allowout at edge E → IDLE, with O_valid low after E.
  - The next I_start arrives no earlier than the cycle after E.
  - In that cycle, O_valid=0 and IDLE accepts the start.
- Reset mid-CALC or mid-DONE: returns to IDLE on the next edge. No O_valid pulse, and O_result is cleared.

## Configuration
YSYX_22040750_MDU_FLUSH_EN:
- Defined: I_flush port exists. I_flush=1 in any state forces IDLE on the next edge with O_valid=0; O_result is not updated. I_flush has priority over I_start in the same cycle.
- Undefined: port absent. Every started op runs to DONE.

## Test plan
- MUL signed, src1=3, src2=0xFFFFFFFFFFFFFFFB (−5): O_valid after 64 cycles, O_result=0xFFFFFFFFFFFFFFF1. Held 4 cycles with I_allowout=0, then accepted; O_valid low next cycle.
- MULHU, src1=src2=0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULHSU, src1=−1, src2=2 → 0xFFFFFFFFFFFFFFFF.
- DIVU 7/0: O_valid 1 cycle after start, result 0xFFFFFFFFFFFFFFFF. REM 7%0 → 7.
- DIVW signed, src1=0x0000000080000000, src2=0xFFFFFFFFFFFFFFFF: O_valid after 32 cycles, result 0xFFFFFFFF80000000. REMW on the same operands → 0.
- REM signed, −7 % 2 → 0xFFFFFFFFFFFFFFFF. DIV signed, −7/2 → 0xFFFFFFFFFFFFFFFD.
- Reset asserted at cycle 20 of a DIV: IDLE with O_valid=0, O_result=0. An immediately following MUL 6*7 → 42.
  - With YSYX_22040750_MDU_FLUSH_EN: I_flush at cycle 10 of a MUL gives no O_valid pulse.
